// File: rtl/reg_if_axil_master.sv
// Register-interface (en/wait/ack) to AXI-Lite master bridge.
// Independent write and read FSMs; one outstanding transaction per direction.
module reg_if_axil_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                  reg_wr_en,
    output logic                  reg_wr_wait,
    output logic                  reg_wr_ack,
    output logic                  reg_wr_err,

    input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                  reg_rd_en,
    output logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  reg_rd_wait,
    output logic                  reg_rd_ack,
    output logic                  reg_rd_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [1:0] {WrIdle, WrSend, WrResp, WrDone} wr_state_e;
    typedef enum logic [1:0] {RdIdle, RdAddr, RdData, RdDone} rd_state_e;

    wr_state_e wr_state;
    rd_state_e rd_state;

    assign m_axil_awprot = PROT;
    assign m_axil_arprot = PROT;

    // A channel is finished once its valid has dropped or is handshaking now.
    logic aw_fin;
    logic w_fin;
    assign aw_fin = !m_axil_awvalid || m_axil_awready;
    assign w_fin  = !m_axil_wvalid  || m_axil_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state       <= WrIdle;
            m_axil_awaddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            reg_wr_wait    <= 1'b0;
            reg_wr_ack     <= 1'b0;
            reg_wr_err     <= 1'b0;
        end else begin
            reg_wr_ack <= 1'b0;
            case (wr_state)
                WrIdle: begin
                    if (reg_wr_en) begin
                        m_axil_awaddr  <= reg_wr_addr;
                        m_axil_wdata   <= reg_wr_data;
                        m_axil_wstrb   <= reg_wr_strb;
                        m_axil_awvalid <= 1'b1;
                        m_axil_wvalid  <= 1'b1;
                        reg_wr_wait    <= 1'b1;
                        wr_state       <= WrSend;
                    end
                end
                WrSend: begin
                    if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        m_axil_bready <= 1'b1;
                        wr_state      <= WrResp;
                    end
                end
                WrResp: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        reg_wr_err    <= (m_axil_bresp != 2'b00);
                        reg_wr_wait   <= 1'b0;
                        reg_wr_ack    <= 1'b1;
                        wr_state      <= WrDone;
                    end
                end
                WrDone: wr_state <= WrIdle;
                default: wr_state <= WrIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state       <= RdIdle;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            reg_rd_data    <= '0;
            reg_rd_wait    <= 1'b0;
            reg_rd_ack     <= 1'b0;
            reg_rd_err     <= 1'b0;
        end else begin
            reg_rd_ack <= 1'b0;
            case (rd_state)
                RdIdle: begin
                    if (reg_rd_en) begin
                        m_axil_araddr  <= reg_rd_addr;
                        m_axil_arvalid <= 1'b1;
                        reg_rd_wait    <= 1'b1;
                        rd_state       <= RdAddr;
                    end
                end
                RdAddr: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        rd_state       <= RdData;
                    end
                end
                RdData: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        reg_rd_data   <= m_axil_rdata;
                        reg_rd_err    <= (m_axil_rresp != 2'b00);
                        reg_rd_wait   <= 1'b0;
                        reg_rd_ack    <= 1'b1;
                        rd_state      <= RdDone;
                    end
                end
                RdDone: rd_state <= RdIdle;
                default: rd_state <= RdIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_if_axil_master.sv
// Self-checking bench for reg_if_axil_master: directed scenarios plus randomized
// traffic against a cycle-timing model and a byte-strobed reference memory.
module tb_reg_if_axil_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_en, reg_wr_wait, reg_wr_ack, reg_wr_err;
    logic        reg_rd_en, reg_rd_wait, reg_rd_ack, reg_rd_err;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [1:0]  m_axil_bresp, m_axil_rresp;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] last_rd_data = 32'h0;
    logic        last_rd_err  = 1'b0;
    logic        last_wr_err  = 1'b0;

    reg_if_axil_master dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_wr_addr    (reg_wr_addr),
        .reg_wr_data    (reg_wr_data),
        .reg_wr_strb    (reg_wr_strb),
        .reg_wr_en      (reg_wr_en),
        .reg_wr_wait    (reg_wr_wait),
        .reg_wr_ack     (reg_wr_ack),
        .reg_wr_err     (reg_wr_err),
        .reg_rd_addr    (reg_rd_addr),
        .reg_rd_en      (reg_rd_en),
        .reg_rd_data    (reg_rd_data),
        .reg_rd_wait    (reg_rd_wait),
        .reg_rd_ack     (reg_rd_ack),
        .reg_rd_err     (reg_rd_err),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cycle 0 = request cycle. Slave readys rise at cycle aw_r / w_r; bvalid is presented
    // bdel cycles after bready is expected to rise.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_r, input int w_r,
                            input int bdel, input logic [1:0] bresp, input int extra_en,
                            input bit stray);
        int ha, hw, rb, hb;
        logic [31:0] got_addr, got_data;
        logic [3:0]  got_strb;
        logic [31:0] old;
        ha = max2(1, aw_r);
        hw = max2(1, w_r);
        rb = max2(ha, hw) + 1;
        hb = rb + bdel;
        got_addr = 32'h0; got_data = 32'h0; got_strb = 4'h0;
        for (int c = 0; c <= hb + 2; c++) begin
            reg_wr_en      = (c == 0) || (c == extra_en);
            reg_wr_addr    = (c == 0) ? addr : $urandom;
            reg_wr_data    = (c == 0) ? data : $urandom;
            reg_wr_strb    = (c == 0) ? strb : 4'($urandom);
            m_axil_awready = (c >= aw_r);
            m_axil_wready  = (c >= w_r);
            m_axil_bvalid  = (c == hb) || (stray && c == 0);
            m_axil_bresp   = (c == hb) ? bresp : 2'b11;
            @(negedge clk);
            check("awvalid", 32'(m_axil_awvalid), 32'(c >= 1 && c <= ha));
            check("wvalid", 32'(m_axil_wvalid), 32'(c >= 1 && c <= hw));
            check("bready", 32'(m_axil_bready), 32'(c >= rb && c <= hb));
            check("wr_wait", 32'(reg_wr_wait), 32'(c >= 1 && c <= hb));
            check("wr_ack", 32'(reg_wr_ack), 32'(c == hb + 1));
            if (m_axil_awvalid) begin
                check("awaddr", m_axil_awaddr, addr);
                check("awprot", 32'(m_axil_awprot), 32'h0);
                if (m_axil_awready) got_addr = m_axil_awaddr;
            end
            if (m_axil_wvalid) begin
                check("wdata", m_axil_wdata, data);
                check("wstrb", 32'(m_axil_wstrb), 32'(strb));
                if (m_axil_wready) begin
                    got_data = m_axil_wdata;
                    got_strb = m_axil_wstrb;
                end
            end
            if (c <= hb) check("wr_err_hold", 32'(reg_wr_err), 32'(last_wr_err));
            else         check("wr_err", 32'(reg_wr_err), 32'(bresp != 2'b00));
            if (c == hb && bresp == 2'b00) begin
                old = slave_mem.exists(got_addr) ? slave_mem[got_addr] : 32'h0;
                slave_mem[got_addr] = merge(old, got_data, got_strb);
            end
            @(posedge clk);
            #1;
        end
        reg_wr_en = 1'b0; m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
        last_wr_err = (bresp != 2'b00);
        if (bresp == 2'b00) begin
            old = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
            ref_mem[addr] = merge(old, data, strb);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_r, input int rdel,
                           input logic [1:0] rresp, input bit stray);
        int ha, hr;
        logic [31:0] got_addr, exp_data;
        ha = max2(1, ar_r);
        hr = ha + 1 + rdel;
        got_addr = 32'h0;
        exp_data = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        for (int c = 0; c <= hr + 2; c++) begin
            reg_rd_en      = (c == 0) || (c == 2);
            reg_rd_addr    = (c == 0) ? addr : $urandom;
            m_axil_arready = (c >= ar_r);
            m_axil_rvalid  = (c == hr) || (stray && c == 0);
            m_axil_rresp   = (c == hr) ? rresp : 2'b11;
            if (c == hr) m_axil_rdata = slave_mem.exists(got_addr) ? slave_mem[got_addr] : 32'h0;
            else         m_axil_rdata = $urandom;
            if (c == hr + 1) reg_rd_en = 1'b0;
            if (c == hr + 2) reg_rd_en = 1'b0;
            @(negedge clk);
            check("arvalid", 32'(m_axil_arvalid), 32'(c >= 1 && c <= ha));
            check("rready", 32'(m_axil_rready), 32'(c >= ha + 1 && c <= hr));
            check("rd_wait", 32'(reg_rd_wait), 32'(c >= 1 && c <= hr));
            check("rd_ack", 32'(reg_rd_ack), 32'(c == hr + 1));
            if (m_axil_arvalid) begin
                check("araddr", m_axil_araddr, addr);
                check("arprot", 32'(m_axil_arprot), 32'h0);
                if (m_axil_arready) got_addr = m_axil_araddr;
            end
            if (c <= hr) begin
                check("rd_data_hold", reg_rd_data, last_rd_data);
                check("rd_err_hold", 32'(reg_rd_err), 32'(last_rd_err));
            end else begin
                check("rd_data", reg_rd_data, exp_data);
                check("rd_err", 32'(reg_rd_err), 32'(rresp != 2'b00));
            end
            @(posedge clk);
            #1;
        end
        reg_rd_en = 1'b0; m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
        last_rd_data = exp_data;
        last_rd_err  = (rresp != 2'b00);
    endtask

    initial begin
        logic [31:0] a, d;
        rst_n = 1'b0;
        reg_wr_en = 1'b0; reg_wr_addr = 32'h0; reg_wr_data = 32'h0; reg_wr_strb = 4'h0;
        reg_rd_en = 1'b0; reg_rd_addr = 32'h0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
        m_axil_bresp = 2'b00; m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
        m_axil_rdata = 32'h0; m_axil_rresp = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_awvalid", 32'(m_axil_awvalid), 32'h0);
        check("rst_wvalid", 32'(m_axil_wvalid), 32'h0);
        check("rst_arvalid", 32'(m_axil_arvalid), 32'h0);
        check("rst_readys", 32'({m_axil_bready, m_axil_rready}), 32'h0);
        check("rst_wait_ack", 32'({reg_wr_wait, reg_wr_ack, reg_rd_wait, reg_rd_ack}), 32'h0);
        check("rst_err", 32'({reg_wr_err, reg_rd_err}), 32'h0);
        check("rst_rd_data", reg_rd_data, 32'h0);
        check("rst_awaddr", m_axil_awaddr, 32'h0);
        check("rst_wdata", m_axil_wdata, 32'h0);
        check("rst_wstrb", 32'(m_axil_wstrb), 32'h0);
        check("rst_araddr", m_axil_araddr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Always-ready slave, with a stray bvalid while idle.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, -1, 1'b1);
        // W accepted first, AW held until cycle 5.
        do_write(32'h14, 32'hCAFEF00D, 4'hF, 5, 1, 0, 2'b00, -1, 1'b0);
        do_write(32'h24, 32'h12345678, 4'hF, 0, 0, 0, 2'b00, -1, 1'b0);
        // Read with SLVERR response.
        do_read(32'h24, 3, 2, 2'b10, 1'b1);
        do_read(32'h10, 0, 0, 2'b00, 1'b0);
        // Concurrent, read answered first; extra wr_en during wait must be ignored.
        fork
            do_write(32'h08, 32'hA5A5A5A5, 4'h5, 3, 3, 2, 2'b00, 2, 1'b0);
            do_read(32'h14, 1, 0, 2'b00, 1'b0);
        join
        do_read(32'h08, 0, 0, 2'b00, 1'b0);
        // Write error response, then long B/R backpressure.
        do_write(32'h18, 32'h0BADF00D, 4'hF, 0, 0, 1, 2'b10, -1, 1'b0);
        fork
            do_write(32'h1C, 32'h55AA55AA, 4'h3, 0, 0, 20, 2'b00, -1, 1'b0);
            do_read(32'h24, 0, 20, 2'b00, 1'b0);
        join

        // Asynchronous reset in the middle of SEND.
        reg_wr_en = 1'b1; reg_wr_addr = 32'h30; reg_wr_data = 32'h11112222; reg_wr_strb = 4'hF;
        @(posedge clk); #1;
        reg_wr_en = 1'b0;
        @(posedge clk); #2;
        check("send_awvalid", 32'(m_axil_awvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_awvalid", 32'(m_axil_awvalid), 32'h0);
        check("arst_wvalid", 32'(m_axil_wvalid), 32'h0);
        check("arst_wait", 32'(reg_wr_wait), 32'h0);
        check("arst_ack", 32'(reg_wr_ack), 32'h0);
        check("arst_awaddr", m_axil_awaddr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_wr_err = 1'b0; last_rd_err = 1'b0; last_rd_data = 32'h0;
        @(posedge clk); #1;
        do_write(32'h30, 32'h33334444, 4'hF, 1, 2, 0, 2'b00, -1, 1'b0);
        do_read(32'h30, 0, 1, 2'b00, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 16; i++) begin
            a = 32'(($urandom % 16) * 4);
            d = $urandom;
            do_write(a, d, 4'($urandom), int'($urandom % 4), int'($urandom % 4),
                     int'($urandom % 3), ($urandom % 4 == 0) ? 2'b10 : 2'b00,
                     ($urandom % 2 == 0) ? 2 : -1, 1'($urandom));
            a = 32'(($urandom % 16) * 4);
            do_read(a, int'($urandom % 4), int'($urandom % 3),
                    ($urandom % 4 == 0) ? 2'b10 : 2'b00, 1'($urandom));
            fork
                do_write(32'(($urandom % 8) * 4), $urandom, 4'($urandom), int'($urandom % 3),
                         int'($urandom % 3), int'($urandom % 3), 2'b00, -1, 1'b0);
                do_read(32'(32 + ($urandom % 8) * 4), int'($urandom % 3), int'($urandom % 3),
                        2'b00, 1'b0);
            join
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
